// File: rtl/cont_mod_updown.sv
// Modulo-(MAX+1) up/down counter with synchronous load, one-shot saturation
// and cascade outputs (combinational Tc, registered Wrap and Done pulses/flags).
module cont_mod_updown #(
  parameter int WIDTH   = 4,
  parameter int MAX     = 9,
  parameter int RST_VAL = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             Up,
  input  logic             OneShot,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Cuenta,
  output logic             Tc,
  output logic             Wrap,
  output logic             Done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             term;
  logic             frozen;

  // Terminal is judged against the direction requested this cycle.
  assign term   = Up ? (cnt_q == MAX_V) : (cnt_q == '0);
  assign frozen = OneShot && done_q;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (Load) begin
      cnt_d  = (LoadVal > MAX_V) ? MAX_V : LoadVal;
      done_d = 1'b0;
    end else if (Enable && !frozen) begin
      if (!term) begin
        cnt_d = Up ? (cnt_q + ONE_V) : (cnt_q - ONE_V);
      end else if (OneShot) begin
        done_d = 1'b1;
      end else begin
        cnt_d  = Up ? '0 : MAX_V;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q  <= RST_V;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  // Unregistered so a following digit advances on the same edge as this wrap.
  assign Tc     = Enable && !Load && Rst && term && !frozen;
  assign Cuenta = cnt_q;
  assign Wrap   = wrap_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_cont_mod_updown.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model, and a two-digit (0..59) cascade.
module tb_cont_mod_updown;

  localparam int MAXV = 9;

  logic       Clk = 1'b0;
  logic       Rst, Enable, Up, OneShot, Load;
  logic [3:0] LoadVal;
  logic [3:0] Cuenta;
  logic       Tc, Wrap, Done;

  logic       c_rst, c_en;
  logic [3:0] c_units;
  logic [2:0] c_tens;
  logic       c_utc, c_ttc, c_uwrap, c_twrap, c_udone, c_tdone;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int m_cnt  = 0;
  int m_wrap = 0;
  int m_done = 0;

  always #5 Clk = ~Clk;

  cont_mod_updown #(.WIDTH(4), .MAX(9), .RST_VAL(0)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Up(Up), .OneShot(OneShot),
    .Load(Load), .LoadVal(LoadVal), .Cuenta(Cuenta), .Tc(Tc), .Wrap(Wrap),
    .Done(Done)
  );

  cont_mod_updown #(.WIDTH(4), .MAX(9), .RST_VAL(0)) u_units (
    .Clk(Clk), .Rst(c_rst), .Enable(c_en), .Up(1'b1), .OneShot(1'b0),
    .Load(1'b0), .LoadVal(4'd0), .Cuenta(c_units), .Tc(c_utc), .Wrap(c_uwrap),
    .Done(c_udone)
  );

  cont_mod_updown #(.WIDTH(3), .MAX(5), .RST_VAL(0)) u_tens (
    .Clk(Clk), .Rst(c_rst), .Enable(c_utc), .Up(1'b1), .OneShot(1'b0),
    .Load(1'b0), .LoadVal(3'd0), .Cuenta(c_tens), .Tc(c_ttc), .Wrap(c_twrap),
    .Done(c_tdone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: terminal test, Tc, and the next state from the counter's rules
  // using plain modulo arithmetic on integers.
  task automatic step(input logic rst, input logic en, input logic up,
                      input logic os, input logic ld, input logic [3:0] lv);
    int t, frozen, m_tc;
    @(negedge Clk);
    Rst = rst; Enable = en; Up = up; OneShot = os; Load = ld; LoadVal = lv;
    #1;
    t      = up ? (m_cnt == MAXV) : (m_cnt == 0);
    frozen = os && m_done;
    m_tc   = rst && en && !ld && t && !frozen;
    chk("tc", 32'(Tc), m_tc);
    @(posedge Clk);
    if (!rst) begin
      m_cnt = 0; m_wrap = 0; m_done = 0;
    end else if (ld) begin
      m_cnt = (int'(lv) > MAXV) ? MAXV : int'(lv);
      m_wrap = 0; m_done = 0;
    end else if (en && !frozen && t && os) begin
      m_done = 1; m_wrap = 0;
    end else if (en && !frozen) begin
      m_wrap = t;
      m_cnt  = up ? (m_cnt + 1) % (MAXV + 1) : (m_cnt + MAXV) % (MAXV + 1);
    end else begin
      m_wrap = 0;
    end
    #1;
    chk("cuenta", 32'(Cuenta), m_cnt);
    chk("wrap",   32'(Wrap),   m_wrap);
    chk("done",   32'(Done),   m_done);
  endtask

  initial begin
    int wrap_pulses;
    int expv;
    Rst = 1'b0; Enable = 1'b0; Up = 1'b1; OneShot = 1'b0; Load = 1'b0; LoadVal = '0;
    c_rst = 1'b0; c_en = 1'b0;

    // Reset then count up through a wrap
    step(0, 0, 1, 0, 0, 4'd0);
    chk("reset_cnt", 32'(Cuenta), 0);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0, 4'd0);
    chk("up12_cnt", 32'(Cuenta), 2);

    // Down wrap from 2
    step(1, 0, 0, 0, 1, 4'd2);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 4'd0);
    chk("down_cnt", 32'(Cuenta), 8);

    // Load clamp beats Enable; reset beats Load
    step(1, 1, 1, 0, 1, 4'd13);
    chk("clamp", 32'(Cuenta), 9);
    step(0, 1, 1, 0, 1, 4'd5);
    chk("rst_over_load", 32'(Cuenta), 0);

    // One-shot saturation, frozen, release by Load
    step(1, 0, 1, 1, 1, 4'd7);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0, 4'd0);
    chk("oneshot_hold", 32'(Cuenta), 9);
    chk("oneshot_done", 32'(Done), 1);
    step(1, 1, 0, 1, 0, 4'd0);
    step(1, 1, 1, 0, 0, 4'd0);
    step(1, 1, 1, 1, 1, 4'd3);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 4'd0);
    chk("oneshot_resume", 32'(Cuenta), 6);

    // Mid-run reset
    step(0, 1, 1, 0, 0, 4'd0);
    chk("midrst_cnt", 32'(Cuenta), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 4'($urandom));
      chk("range", 32'(Cuenta <= 4'(MAXV)), 1);
    end

    // Two-digit cascade 00..59..00
    @(negedge Clk);
    c_rst = 1'b0; c_en = 1'b0;
    @(negedge Clk);
    c_rst = 1'b1; c_en = 1'b1;
    wrap_pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clk);
      #1;
      expv = k % 60;
      chk("casc_units", 32'(c_units), expv % 10);
      chk("casc_tens",  32'(c_tens),  expv / 10);
      chk("casc_twrap", 32'(c_twrap), (k == 60) ? 1 : 0);
      if (c_twrap === 1'b1) wrap_pulses++;
    end
    chk("casc_pulses", wrap_pulses, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cont_mod_updown.md
Name: cont_mod_updown

Overview:
- Parametrised successor to the fixed 2-bit 0..3 counter: modulo-(MAX+1) up/down counter with synchronous load, one-shot (saturate) mode and cascade outputs.
- Used as a digit/prescaler element; several instances chain via Tc into Enable to build multi-digit BCD or time-base counters.
- Single clock domain; all state registered on the rising edge of Clk.

Parameters:
- WIDTH, 4, bit width of Cuenta and LoadVal; must satisfy MAX < 2**WIDTH.
- MAX, 9, terminal value; count range is 0..MAX inclusive.
- RST_VAL, 0, value Cuenta takes on reset; must be <= MAX.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  synchronous reset, active-low: Rst==0 at a rising edge resets all state.
- Enable  input  1  count enable for this cycle.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- OneShot  input  1  1 = saturate at terminal and stop; 0 = wrap-around.
- Load  input  1  synchronous load strobe.
- LoadVal  input  WIDTH  value to load.
- Cuenta  output  WIDTH  current count (registered).
- Tc  output  1  terminal-count, combinational, for cascading.
- Wrap  output  1  registered one-cycle pulse after a wrap event.
- Done  output  1  registered sticky flag: one-shot run reached terminal.

Behaviour:
- Priority per rising edge: Rst==0 > Load > Enable > hold.
- Reset: Cuenta=RST_VAL, Wrap=0, Done=0.
- Load: Cuenta = LoadVal if LoadVal <= MAX, else MAX (clamped). Done=0, Wrap=0. Enable ignored that cycle.
- Terminal in current direction: T = (Up && Cuenta==MAX) || (!Up && Cuenta==0).
- Enable=1, not T: Cuenta +1 (Up) or -1 (down), modulo arithmetic within WIDTH bits. Wrap=0.
- Enable=1, T, OneShot=0: Cuenta wraps (MAX->0 up, 0->MAX down). Wrap=1 for exactly the next cycle.
- Enable=1, T, OneShot=1: Cuenta holds at terminal, Done=1 (sticky until Load or reset). Wrap=0.
- Done=1 and OneShot=1: counter frozen even if Enable=1. Changing OneShot to 0 releases it; Done stays 1 until Load or reset.
- Up may change any cycle; T is re-evaluated against the current Up value.
- Enable=0: Cuenta, Done hold; Wrap=0.
- Tc = Enable && Load==0 && Rst==1 && T && !(OneShot && Done). Tc is combinational with no register; it feeds the next digit's Enable so the cascade advances in the same edge the wrap occurs.
- Latency: Cuenta updates 1 cycle after the qualifying edge. Wrap and Done are asserted in the cycle following the event.
- Cuenta never exceeds MAX under any input sequence after reset.

Test Plan:
- Reset/count up: Rst=0 one cycle, then Enable=1, Up=1, 12 cycles -> Cuenta 0,1..9,0,1,2; Wrap=1 only in the cycle Cuenta=0 after 9; Tc=1 only while Cuenta=9.
- Down wrap: Load LoadVal=2, Up=0, Enable=1 -> 2,1,0,9,8; Wrap pulses once after 0->9; Tc=1 while Cuenta=0.
- Load clamp and priority: LoadVal=13 with Load=1, Enable=1 -> Cuenta=9 (no increment). Next cycle Rst=0 with Load=1, LoadVal=5 -> Cuenta=0.
- One-shot: OneShot=1, Up=1, Enable=1 from 7 -> 8, 9, 9, 9; Done=1 from the cycle after 9 is seen with Enable; Wrap stays 0; Tc=1 for one cycle only. Load 3 -> Done=0, counting resumes.
- Cascade: two instances (units MAX=9, tens MAX=5), units Tc to tens Enable, 60 enabled cycles -> tens:units goes 0:0..5:9 then 0:0; tens Wrap pulses once.
- Mid-run reset: counting at 6 with Enable=1, Rst=0 -> next Cuenta=RST_VAL(0), Done=0, Wrap=0; Tc=0 during the reset cycle.
